unified_mem_sequencer: RTL and testbench
========================================

// Module: unified_mem_sequencer
// PURPOSE
//  Sequences the single-cycle core's separate instruction and data ports onto one
//  shared, variable-latency, single-port memory. Sits between the core and memory.
//  Gates core state updates through core_advance, one instruction at a time.
//  Provides a bus-timeout guard and performance counters.
// PARAMETERS
//  TIMEOUT_CYCLES  256  cycles without mem_ready before one access is aborted
//  CNT_WIDTH       32   width of perf counters inst_count and stall_count
// PORTS
//  clock         in   1          single clock, rising edge
//  reset         in   1          asynchronous, active-low
//  inst_add      in   word       core fetch address (pc)
//  inst_data     out  word       held instruction presented to core
//  data_add      in   word       core data address
//  data_out      in   word       core store data
//  data_mem_op   in   mem_en_t   core data op: MEM_NONE/MEM_READ/MEM_WRITE
//  data_mem_en   in   word       core byte enables; bits [3:0] used
//  data_in       out  word       load data returned to core
//  core_advance  out  1          1-cycle pulse: core commits pc + regfile this edge
//  mem_req       out  1          memory request valid
//  mem_we        out  1          1 = write
//  mem_addr      out  word       word-aligned address {addr[31:2],2'b00}
//  mem_wdata     out  word       write data
//  mem_be        out  4          byte enables (4'hF for fetch)
//  mem_ready     in   1          access complete; mem_rdata valid same cycle
//  mem_rdata     in   word       read data
//  bus_error     out  1          sticky: a timeout occurred
//  inst_count    out  CNT_WIDTH  retired instructions (core_advance pulses)
//  stall_count   out  CNT_WIDTH  cycles with core_advance=0 outside reset
// BEHAVIOUR
//  Reset values: state=FETCH; mem_req=0; core_advance=0; inst_data=32'h0000_0013 (NOP);
//   data_in=0; bus_error=0; counters=0; timeout counter=0.
//  FSM, one state per cycle minimum:
//   FETCH : mem_req=1, we=0, be=F, addr=inst_add. On mem_ready: latch rdata into
//           inst_buf; go to EXEC.
//   EXEC  : inst_data=inst_buf; core decodes combinationally.
//           data_mem_op==MEM_NONE: core_advance=1; go to FETCH.
//           Otherwise: register addr, wdata, be[3:0], we; go to DATA.
//   DATA  : mem_req=1 with registered fields. On mem_ready: latch rdata into
//           data_buf (reads only); go to COMMIT.
//   COMMIT: data_in=data_buf; core_advance=1; go to FETCH.
//  Latency with zero-wait memory: 2 cycles for non-memory instructions, 4 for
//   loads/stores. Each memory wait cycle adds 1.
//  Handshake rules:
//   - mem_req and all mem_* fields are stable from assertion until the mem_ready
//     cycle; no retraction.
//   - mem_ready may arrive in the first req cycle.
//   - mem_ready while mem_req=0 is ignored.
//   - mem_req deasserts the cycle after ready.
//  Timeout:
//   - Counter increments each req cycle without ready and clears on ready or
//     state change.
//   - At TIMEOUT_CYCLES-1, abort the access and set bus_error.
//   - FETCH abort: inst_buf=NOP, go to EXEC.
//   - DATA abort: data_buf=32'hDEAD_BEEF, go to COMMIT.
//   - The core always advances after an abort.
//  inst_data holds its value outside EXEC, so core decode stays stable in DATA/COMMIT.
//  Counters wrap modulo 2^CNT_WIDTH. stall_count counts every cycle with
//   core_advance=0.
//  Reset asserted mid-access: mem_req drops asynchronously; the memory must tolerate
//   an abandoned request. Restart begins with FETCH of the core's reset pc.
//  Misaligned addresses are not checked; byte lanes come from data_mem_en.
// STRUCTURE
//  Shared package (params.sv): mem_en_t, word, the new seq_state_t enum
//   {FETCH,EXEC,DATA,COMMIT}, and constant NOP_INST=32'h0000_0013.
//  One sub-module: seq_timeout_counter (count/clear/expire), instantiated once.
//  FSM, buffers and perf counters stay in this module.
// TESTING
//  1) Zero-wait memory, ADDI at 0x0 -> mem_addr=0, core_advance on cycle 2;
//     inst_count=1; stall_count=1.
//  2) LW x1,0(x2) with x2=0x100 and memory returning 0xCAFE_F00D after 3 waits ->
//     DATA req addr=0x100, we=0; data_in=0xCAFE_F00D in COMMIT; 7 cycles total.
//  3) SB to 0x203 with be=4'b1000 -> mem_addr=0x200, mem_be=4'b1000, we=1;
//     fields stable through 2 wait cycles.
//  4) mem_ready never asserted, TIMEOUT_CYCLES=8 -> abort after 8 req cycles;
//     bus_error=1 stays set; inst_data=NOP; core_advance pulses.
//  5) reset deasserted-to-0 in DATA with mem_req=1 -> mem_req=0 immediately;
//     all outputs at reset values; the first access after release is FETCH.
//  6) mem_ready pulse while idle in EXEC -> ignored, no state change.
//     Spurious ready in FETCH with req=1 -> accepted normally.

Source files
------------

// File: rtl/unified_mem_sequencer_pkg.sv
// Shared types and constants for the unified memory sequencer.
package unified_mem_sequencer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef logic [WORD_W-1:0] word;

  // Core data-port operation.
  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_READ  = 2'd1,
    MEM_WRITE = 2'd2
  } mem_en_t;

  // Sequencer phases; each lasts at least one cycle.
  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    DATA   = 2'd2,
    COMMIT = 2'd3
  } seq_state_t;

  // Data access captured in EXEC and replayed unchanged for the whole DATA phase.
  typedef struct packed {
    word             addr;
    word             wdata;
    logic [BE_W-1:0] be;
    logic            we;
  } data_req_t;

  localparam word NOP_INST   = 32'h0000_0013;
  localparam word ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/unified_mem_sequencer_seq_timeout_counter.sv
// Counts consecutive request cycles without ready; flags expiry on the last allowed cycle.
module unified_mem_sequencer_seq_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clock,
  input  logic reset,
  input  logic count_en,
  output logic expire_c
);

  localparam int unsigned CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_c = count_en && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  // Advance while waiting; any ready, idle cycle or abort returns the count to zero.
  always_comb begin
    cnt_d = '0;
    if (count_en && !expire_c) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/unified_mem_sequencer.sv
// Serialises core fetch and data accesses onto one variable-latency memory port,
// gating core commits through core_advance.
module unified_mem_sequencer
  import unified_mem_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  word                  inst_add,
  output word                  inst_data,
  input  word                  data_add,
  input  word                  data_out,
  input  mem_en_t              data_mem_op,
  input  word                  data_mem_en,
  output word                  data_in,
  output logic                 core_advance,
  output logic                 mem_req,
  output logic                 mem_we,
  output word                  mem_addr,
  output word                  mem_wdata,
  output logic [BE_W-1:0]      mem_be,
  input  logic                 mem_ready,
  input  word                  mem_rdata,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] inst_count,
  output logic [CNT_WIDTH-1:0] stall_count
);

  seq_state_t           state_q, state_d;
  word                  inst_buf_q, inst_buf_d;
  word                  data_buf_q, data_buf_d;
  data_req_t            dreq_q, dreq_d;
  logic                 bus_error_q, bus_error_d;
  logic [CNT_WIDTH-1:0] inst_cnt_q, inst_cnt_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

  logic in_req_c;
  logic adv_c;
  logic expire_c;
  logic unused_bits;

  // Reset level gates the request so an in-flight access is dropped asynchronously.
  assign in_req_c    = reset && ((state_q == FETCH) || (state_q == DATA));
  assign adv_c       = ((state_q == EXEC) && (data_mem_op == MEM_NONE)) || (state_q == COMMIT);
  assign unused_bits = ^{inst_add[1:0], data_add[1:0], data_mem_en[WORD_W-1:BE_W]};

  unified_mem_sequencer_seq_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock    (clock),
    .reset    (reset),
    .count_en (in_req_c && !mem_ready),
    .expire_c (expire_c)
  );

  // Memory-side view: fetch uses the live pc, data replays the captured request.
  always_comb begin
    mem_req   = in_req_c;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (in_req_c) begin
      if (state_q == FETCH) begin
        mem_addr = {inst_add[WORD_W-1:2], 2'b00};
        mem_be   = 4'hF;
      end else begin
        mem_we    = dreq_q.we;
        mem_addr  = dreq_q.addr;
        mem_wdata = dreq_q.wdata;
        mem_be    = dreq_q.be;
      end
    end
  end

  assign core_advance = adv_c;
  assign inst_data    = inst_buf_q;
  assign data_in      = data_buf_q;
  assign bus_error    = bus_error_q;
  assign inst_count   = inst_cnt_q;
  assign stall_count  = stall_cnt_q;

  // Next-state, buffer capture, timeout aborts and perf counters.
  always_comb begin
    state_d     = state_q;
    inst_buf_d  = inst_buf_q;
    data_buf_d  = data_buf_q;
    dreq_d      = dreq_q;
    bus_error_d = bus_error_q;
    inst_cnt_d  = inst_cnt_q;
    stall_cnt_d = stall_cnt_q;

    case (state_q)
      FETCH: begin
        if (in_req_c && mem_ready) begin
          inst_buf_d = mem_rdata;
          state_d    = EXEC;
        end else if (expire_c) begin
          inst_buf_d  = NOP_INST;
          bus_error_d = 1'b1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (data_mem_op == MEM_NONE) begin
          state_d = FETCH;
        end else begin
          dreq_d.addr  = {data_add[WORD_W-1:2], 2'b00};
          dreq_d.wdata = data_out;
          dreq_d.be    = data_mem_en[BE_W-1:0];
          dreq_d.we    = (data_mem_op == MEM_WRITE);
          state_d      = DATA;
        end
      end
      DATA: begin
        if (in_req_c && mem_ready) begin
          if (!dreq_q.we) begin
            data_buf_d = mem_rdata;
          end
          state_d = COMMIT;
        end else if (expire_c) begin
          data_buf_d  = ABORT_DATA;
          bus_error_d = 1'b1;
          state_d     = COMMIT;
        end
      end
      COMMIT: begin
        state_d = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase

    if (adv_c) begin
      inst_cnt_d = inst_cnt_q + CNT_WIDTH'(1);
    end else begin
      stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
    end
  end

  // State, buffers and counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= FETCH;
      inst_buf_q  <= NOP_INST;
      data_buf_q  <= '0;
      dreq_q      <= '0;
      bus_error_q <= 1'b0;
      inst_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      inst_buf_q  <= inst_buf_d;
      data_buf_q  <= data_buf_d;
      dreq_q      <= dreq_d;
      bus_error_q <= bus_error_d;
      inst_cnt_q  <= inst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_sequencer.sv
// Directed, table-driven bench for unified_mem_sequencer acting as both core and memory.
module tb_unified_mem_sequencer;
  import unified_mem_sequencer_pkg::*;

  localparam int unsigned TO = 8;
  localparam int unsigned CW = 32;

  logic          clock;
  logic          reset;
  word           inst_add, inst_data, data_add, data_out, data_mem_en, data_in;
  mem_en_t       data_mem_op;
  logic          core_advance, mem_req, mem_we, mem_ready, bus_error;
  word           mem_addr, mem_wdata, mem_rdata;
  logic [3:0]    mem_be;
  logic [CW-1:0] inst_count, stall_count;

  unified_mem_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)) dut (
    .clock        (clock),
    .reset        (reset),
    .inst_add     (inst_add),
    .inst_data    (inst_data),
    .data_add     (data_add),
    .data_out     (data_out),
    .data_mem_op  (data_mem_op),
    .data_mem_en  (data_mem_en),
    .data_in      (data_in),
    .core_advance (core_advance),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_be       (mem_be),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .bus_error    (bus_error),
    .inst_count   (inst_count),
    .stall_count  (stall_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    word        pc;
    mem_en_t    op;
    word        dadd;
    word        dout;
    logic [3:0] be;
    int         fwait;     // wait cycles before fetch ready (>= TO: never)
    int         dwait;     // wait cycles before data ready (>= TO: never)
    word        finst;
    word        drd;
    bit         spur;      // drive mem_ready while no request is pending
    int         exp_lat;
    word        exp_maddr;
    logic [3:0] exp_be;
    bit         exp_we;
    word        exp_inst;
    word        exp_din;
    bit         exp_berr;
  } vec_t;

  int   total  = 0;
  int   passed = 0;
  vec_t vecs[9];
  logic [CW-1:0] exp_icnt = '0;
  logic [CW-1:0] exp_scnt = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic vec_t mk(word pc, mem_en_t op, word dadd, word dout, logic [3:0] be,
                              int fw, int dw, word finst, word drd, bit spur, int lat,
                              word maddr, bit we, word einst, word din, bit berr);
    vec_t v;
    v.pc = pc; v.op = op; v.dadd = dadd; v.dout = dout; v.be = be;
    v.fwait = fw; v.dwait = dw; v.finst = finst; v.drd = drd; v.spur = spur;
    v.exp_lat = lat; v.exp_maddr = maddr; v.exp_be = be; v.exp_we = we;
    v.exp_inst = einst; v.exp_din = din; v.exp_berr = berr;
    return v;
  endfunction

  // One instruction: bench plays core and memory, tracks the expected phase itself.
  task automatic run_vec(input int idx);
    vec_t v;
    int   st, cnt, lat;
    bit   done, f_ok, d_ok, h_ok, exp_req, exp_adv;
    word  got_inst, got_din;
    v = vecs[idx];
    st = 0; cnt = 0; lat = 0; done = 0; f_ok = 1; d_ok = 1; h_ok = 1;
    got_inst = '0; got_din = '0;
    inst_add = v.pc; data_mem_op = v.op; data_add = v.dadd; data_out = v.dout;
    data_mem_en = {28'hFFF_FFF0, v.be};
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clock);
      mem_ready = 1'b0;
      mem_rdata = 32'hBAD0_BAD0;
      if (st == 0) begin
        mem_ready = (cnt == v.fwait); mem_rdata = v.finst;
      end else if (st == 2) begin
        mem_ready = (cnt == v.dwait); mem_rdata = v.drd;
      end else begin
        mem_ready = v.spur;
      end
      #1;
      lat++;
      exp_req = (st == 0) || (st == 2);
      exp_adv = ((st == 1) && (v.op == MEM_NONE)) || (st == 3);
      if (mem_req !== exp_req || core_advance !== exp_adv) h_ok = 0;
      if (st == 0 && (mem_addr !== {v.pc[31:2], 2'b00} || mem_we !== 1'b0 || mem_be !== 4'hF))
        f_ok = 0;
      if (st == 2 && (mem_addr !== v.exp_maddr || mem_be !== v.exp_be || mem_we !== v.exp_we ||
                      (v.exp_we && mem_wdata !== v.dout)))
        d_ok = 0;
      if (core_advance === 1'b1) begin
        done = 1; got_inst = inst_data; got_din = data_in;
      end
      case (st)
        0, 2: begin
          if (mem_ready || cnt == int'(TO) - 1) begin st = st + 1; cnt = 0; end
          else cnt++;
        end
        1:       st = (v.op == MEM_NONE) ? 0 : 2;
        default: st = 0;
      endcase
    end
    mem_ready = 1'b0;
    @(posedge clock); #1;
    exp_icnt = exp_icnt + 1;
    exp_scnt = exp_scnt + CW'(v.exp_lat - 1);
    check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.exp_lat));
    check($sformatf("v%0d handshake", idx), 64'(h_ok), 64'd1);
    check($sformatf("v%0d fetch_fields", idx), 64'(f_ok), 64'd1);
    if (v.op != MEM_NONE) check($sformatf("v%0d data_fields", idx), 64'(d_ok), 64'd1);
    check($sformatf("v%0d inst_data", idx), 64'(got_inst), 64'(v.exp_inst));
    check($sformatf("v%0d data_in", idx), 64'(got_din), 64'(v.exp_din));
    check($sformatf("v%0d bus_error", idx), 64'(bus_error), 64'(v.exp_berr));
    check($sformatf("v%0d inst_count", idx), 64'(inst_count), 64'(exp_icnt));
    check($sformatf("v%0d stall_count", idx), 64'(stall_count), 64'(exp_scnt));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " mem_req"}, 64'(mem_req), 64'd0);
    check({tag, " core_advance"}, 64'(core_advance), 64'd0);
    check({tag, " inst_data"}, 64'(inst_data), 64'h13);
    check({tag, " data_in"}, 64'(data_in), 64'd0);
    check({tag, " bus_error"}, 64'(bus_error), 64'd0);
    check({tag, " inst_count"}, 64'(inst_count), 64'd0);
    check({tag, " stall_count"}, 64'(stall_count), 64'd0);
  endtask

  initial begin
    //            pc         op         dadd          dout          be     fw  dw  finst         drd           sp lat maddr        we  einst         din           berr
    vecs[0] = mk(32'h00, MEM_NONE,  32'h0,     32'h0,         4'hF,  0,  0, 32'h0010_0093, 32'h0,         0, 2,  32'h0,       0, 32'h0010_0093, 32'h0,         0);
    vecs[1] = mk(32'h04, MEM_READ,  32'h100,   32'h0,         4'hF,  0,  3, 32'h0001_2083, 32'hCAFE_F00D, 0, 7,  32'h100,     0, 32'h0001_2083, 32'hCAFE_F00D, 0);
    vecs[2] = mk(32'h08, MEM_WRITE, 32'h203,   32'hAB00_0000, 4'h8,  0,  2, 32'h00B1_01A3, 32'h0,         0, 6,  32'h200,     1, 32'h00B1_01A3, 32'hCAFE_F00D, 0);
    vecs[3] = mk(32'h0C, MEM_NONE,  32'h0,     32'h0,         4'hF,  2,  0, 32'h0020_8113, 32'h0,         0, 4,  32'h0,       0, 32'h0020_8113, 32'hCAFE_F00D, 0);
    vecs[4] = mk(32'h10, MEM_READ,  32'h444,   32'h0,         4'hF,  1,  0, 32'h4440_2183, 32'h1234_5678, 1, 5,  32'h444,     0, 32'h4440_2183, 32'h1234_5678, 0);
    vecs[5] = mk(32'h14, MEM_WRITE, 32'h2FE,   32'hDEAD_C0DE, 4'hF,  0,  0, 32'h2E11_2F23, 32'h0,         0, 4,  32'h2FC,     1, 32'h2E11_2F23, 32'h1234_5678, 0);
    vecs[6] = mk(32'h18, MEM_NONE,  32'h0,     32'h0,         4'hF, 99,  0, 32'hFFFF_FFFF, 32'h0,         0, 9,  32'h0,       0, 32'h0000_0013, 32'h1234_5678, 1);
    vecs[7] = mk(32'h1C, MEM_READ,  32'h80,    32'h0,         4'hF,  0, 99, 32'h0800_2203, 32'h5555_5555, 0, 11, 32'h80,      0, 32'h0800_2203, 32'hDEAD_BEEF, 1);
    vecs[8] = mk(32'h20, MEM_NONE,  32'h0,     32'h0,         4'hF,  0,  0, 32'h0030_0293, 32'h0,         0, 2,  32'h0,       0, 32'h0030_0293, 32'hDEAD_BEEF, 1);

    reset = 1'b0; mem_ready = 1'b0; mem_rdata = '0;
    inst_add = '0; data_add = '0; data_out = '0; data_mem_en = '0; data_mem_op = MEM_NONE;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("por");

    @(posedge clock); #2;
    reset = 1'b1;
    for (int i = 0; i < 9; i++) run_vec(i);

    // Reset while a load is waiting in DATA.
    inst_add = 32'h40; data_mem_op = MEM_READ; data_add = 32'h100; data_mem_en = 32'hF;
    @(negedge clock); mem_ready = 1'b1; mem_rdata = 32'h0001_2083;   // FETCH
    @(negedge clock); mem_ready = 1'b0;                              // EXEC
    @(negedge clock); #1;                                            // DATA, 1st wait
    check("mid DATA mem_req", 64'(mem_req), 64'd1);
    check("mid DATA mem_addr", 64'(mem_addr), 64'h100);
    @(negedge clock);                                                // DATA, 2nd wait
    reset = 1'b0;
    #1;
    check_reset_values("mid reset");
    check("mid reset mem_we", 64'(mem_we), 64'd0);
    @(posedge clock); #2;
    inst_add = 32'h0; data_mem_op = MEM_NONE;
    reset = 1'b1;
    @(negedge clock); #1;
    check("restart mem_req", 64'(mem_req), 64'd1);
    check("restart fetch addr", 64'(mem_addr), 64'h0);
    check("restart fetch we", 64'(mem_we), 64'd0);
    check("restart fetch be", 64'(mem_be), 64'hF);
    mem_ready = 1'b1; mem_rdata = 32'h0010_0093;
    @(negedge clock); mem_ready = 1'b0; #1;
    check("restart advance", 64'(core_advance), 64'd1);
    check("restart inst_data", 64'(inst_data), 64'h0010_0093);
    @(posedge clock); #1;
    check("restart inst_count", 64'(inst_count), 64'd1);
    check("restart stall_count", 64'(stall_count), 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
